// File: rtl/ls161a_down.sv
// Synchronous presettable down-counter modelled on the 74LS161A, counting down, with borrow out and a sticky underflow flag.
// Optional build macro LS161A_DOWN_AUTO_RELOAD_EN: a decrement from zero reloads the last loaded value.
module ls161a_down #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             UF
);

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_DEC   = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_CLEAR = 2'd3
  } action_t;

  action_t          action;
  logic             at_zero;
  logic [WIDTH-1:0] wrap_value;
  logic [WIDTH-1:0] q_next;
  logic             uf_next;

  assign at_zero = (Q == '0);

  // Borrow ignores ENP so a cascade stage can ripple its enable forward.
  assign BO = ENT & at_zero;

`ifdef LS161A_DOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      reload <= '1;
    end else if (!LOAD_n) begin
      reload <= D;
    end
  end

  assign wrap_value = reload;
`else
  assign wrap_value = '1;
`endif

  always_comb begin
    action = ACT_HOLD;
    if (!CLR_n) begin
      action = ACT_CLEAR;
    end else if (!LOAD_n) begin
      action = ACT_LOAD;
    end else if (ENP && ENT) begin
      action = ACT_DEC;
    end
  end

  always_comb begin
    q_next  = Q;
    uf_next = UF;
    case (action)
      ACT_CLEAR: begin
        q_next  = '0;
        uf_next = 1'b0;
      end
      ACT_LOAD: begin
        q_next  = D;
        uf_next = 1'b0;
      end
      ACT_DEC: begin
        if (at_zero) begin
          q_next  = wrap_value;
          uf_next = 1'b1;
        end else begin
          q_next = Q - 1'b1;
        end
      end
      default: begin
        q_next  = Q;
        uf_next = UF;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    Q  <= q_next;
    UF <= uf_next;
  end

endmodule

// File: tb/tb_ls161a_down.sv
// Directed bench for ls161a_down: clear, load/count, enable gating, priority, cascade and wrap/reload behaviour.
module tb_ls161a_down;

  logic       CLK;
  logic       CLR_n;
  logic [3:0] D;
  logic       LOAD_n;
  logic       ENP;
  logic       ENT;
  logic [3:0] Q;
  logic       BO;
  logic       UF;

  logic [3:0] d_lo;
  logic [3:0] d_hi;
  logic [3:0] q_lo;
  logic [3:0] q_hi;
  logic       bo_lo;
  logic       bo_hi;
  logic       uf_lo;
  logic       uf_hi;
  logic       ent_c;

  int compared = 0;
  int mismatched = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  ls161a_down #(.WIDTH(4)) dut (
    .CLK(CLK), .CLR_n(CLR_n), .D(D), .LOAD_n(LOAD_n),
    .ENP(ENP), .ENT(ENT), .Q(Q), .BO(BO), .UF(UF)
  );

  ls161a_down #(.WIDTH(4)) u_lo (
    .CLK(CLK), .CLR_n(CLR_n), .D(d_lo), .LOAD_n(LOAD_n),
    .ENP(ENP), .ENT(ent_c), .Q(q_lo), .BO(bo_lo), .UF(uf_lo)
  );

  ls161a_down #(.WIDTH(4)) u_hi (
    .CLK(CLK), .CLR_n(CLR_n), .D(d_hi), .LOAD_n(LOAD_n),
    .ENP(ENP), .ENT(bo_lo), .Q(q_hi), .BO(bo_hi), .UF(uf_hi)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    CLR_n = 1'b0; LOAD_n = 1'b0; D = 4'h9; ENP = 1'b1; ENT = 1'b1;
    d_lo = 4'h0; d_hi = 4'h0; ent_c = 1'b0;
    step();
    check("clr_q", Q, 4'h0);
    check("clr_uf", UF, 1'b0);
    check("clr_bo", BO, 1'b1);
    ENT = 1'b0; #1;
    check("clr_bo_ent0", BO, 1'b0);

    CLR_n = 1'b1; LOAD_n = 1'b0; D = 4'h3; ENP = 1'b0; ENT = 1'b0;
    step();
    LOAD_n = 1'b1; ENP = 1'b1; ENT = 1'b1; #1;
    check("ld_q3", Q, 4'h3);
    check("ld_bo3", BO, 1'b0);
    step();
    check("cnt_q2", Q, 4'h2);
    step();
    check("cnt_q1", Q, 4'h1);
    check("cnt_bo1", BO, 1'b0);
    step();
    check("cnt_q0", Q, 4'h0);
    check("cnt_bo0", BO, 1'b1);
    check("cnt_uf0", UF, 1'b0);
    step();
    check("cnt_wrap_q", Q, 4'hF);
    check("cnt_wrap_bo", BO, 1'b0);
    check("cnt_wrap_uf", UF, 1'b1);
    step();
    check("cnt_qe", Q, 4'hE);
    check("uf_sticky", UF, 1'b1);

    LOAD_n = 1'b0; D = 4'h5; ENP = 1'b0;
    step();
    check("ld5_uf", UF, 1'b0);
    LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("gate_enp_q", Q, 4'h5);
    check("gate_enp_bo", BO, 1'b0);
    ENP = 1'b1; ENT = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("gate_ent_q", Q, 4'h5);
    check("gate_ent_bo", BO, 1'b0);

    LOAD_n = 1'b0; D = 4'h0; ENP = 1'b0; ENT = 1'b0;
    step();
    LOAD_n = 1'b1; ENP = 1'b1; ENT = 1'b1;
    for (int i = 0; i < 14; i++) step();
    check("pri_pre_q", Q, 4'h2);
    check("pri_pre_uf", UF, 1'b1);
    LOAD_n = 1'b0; D = 4'hA;
    step();
    check("pri_q", Q, 4'hA);
    check("pri_uf", UF, 1'b0);

    LOAD_n = 1'b1;
    step();
    check("mid_q9", Q, 4'h9);
    CLR_n = 1'b0;
    step();
    check("mid_clr_q", Q, 4'h0);
    check("mid_clr_uf", UF, 1'b0);

    CLR_n = 1'b1; ENP = 1'b1;
    step();
`ifdef LS161A_DOWN_AUTO_RELOAD_EN
    check("rst_wrap_q", Q, 4'hF);
`else
    check("wrap_ones_q", Q, 4'hF);
`endif
    check("rst_wrap_uf", UF, 1'b1);

    LOAD_n = 1'b0; d_lo = 4'h1; d_hi = 4'h0; ENP = 1'b0; ent_c = 1'b1; ENT = 1'b0;
    step();
    LOAD_n = 1'b1; ENP = 1'b1; #1;
    check("cas_01", {q_hi, q_lo}, 8'h01);
    step();
    check("cas_00", {q_hi, q_lo}, 8'h00);
    check("cas_bo_lo", bo_lo, 1'b1);
    step();
    check("cas_ff", {q_hi, q_lo}, 8'hFF);
    check("cas_uf_hi", uf_hi, 1'b1);
    step();
    check("cas_fe", {q_hi, q_lo}, 8'hFE);

`ifdef LS161A_DOWN_AUTO_RELOAD_EN
    LOAD_n = 1'b0; D = 4'h2; ENP = 1'b0; ENT = 1'b0;
    step();
    LOAD_n = 1'b1; ENP = 1'b1; ENT = 1'b1;
    step(); check("ar_q1", Q, 4'h1);
    step(); check("ar_q0", Q, 4'h0);
    check("ar_uf0", UF, 1'b0);
    step(); check("ar_q2", Q, 4'h2);
    check("ar_uf1", UF, 1'b1);
    step(); check("ar_q1b", Q, 4'h1);
    step(); check("ar_q0b", Q, 4'h0);
    step(); check("ar_q2b", Q, 4'h2);
    CLR_n = 1'b0;
    step();
    CLR_n = 1'b1;
    step();
    check("ar_rst_f", Q, 4'hF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ls161a_down.md
LS161A_DOWN -- requirements
Module: ls161a_down

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port CLR_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port D, input, WIDTH bits: parallel preset data.
REQ-005 The block SHALL have port LOAD_n, input, 1 bit: synchronous parallel load, active-low.
REQ-006 The block SHALL have port ENP, input, 1 bit: count enable parallel.
REQ-007 The block SHALL have port ENT, input, 1 bit: count enable trickle, which also gates BO.
REQ-008 The block SHALL have port Q, output, WIDTH bits: current count, registered.
REQ-009 The block SHALL have port BO, output, 1 bit: borrow out (terminal count); combinational, high when ENT=1 and Q=0.
REQ-010 The block SHALL have port UF, output, 1 bit: sticky underflow flag, registered.

Function
REQ-011 On each rising CLK edge the block SHALL apply one action in this priority order: clear (CLR_n=0), load (LOAD_n=0), decrement (ENP=1 and ENT=1), hold.
REQ-012 A load SHALL set Q<=D and UF<=0, regardless of ENP and ENT.
REQ-013 A decrement SHALL set Q<=Q-1 modulo 2^WIDTH; when Q=0 it SHALL wrap to the wrap value (REQ-020/021).
REQ-014 A decrement taken while Q=0 SHALL set UF<=1; UF SHALL remain 1 until a clear or a load.
REQ-015 With ENP=0 or ENT=0 and no clear or load, Q and UF SHALL hold.
REQ-016 BO SHALL equal ENT AND (Q==0) with zero latency, independent of ENP, LOAD_n and CLR_n.
REQ-017 Cascading SHALL be supported without glue logic: stage n BO drives stage n+1 ENT, and all stages share CLK and ENP.
REQ-018 Q and UF SHALL change only on a rising CLK edge, never asynchronously.

Reset
REQ-019 With CLR_n=0 at a rising CLK edge, the block SHALL set Q<=0 and UF<=0, and any reload register to all ones; this overrides a simultaneous load or count, and a clear mid-count takes effect on that same edge.

Configuration
REQ-020 With macro LS161A_DOWN_AUTO_RELOAD_EN defined, the block SHALL contain a WIDTH-bit reload register:
- the register SHALL capture D on every load;
- the register SHALL reset to all ones;
- a decrement from Q=0 SHALL set Q<=reload register, and UF SHALL still set.
REQ-021 With the macro undefined, the reload register SHALL not exist, and a decrement from Q=0 SHALL wrap Q to all ones (2^WIDTH-1); ports SHALL be identical in both builds.

Verification
REQ-022 Clear: CLR_n=0 together with LOAD_n=0 and D=4'h9 for one edge -> Q=0, UF=0; BO=1 while ENT=1.
REQ-023 Load and count: load D=4'h3, then ENP=ENT=1 for 4 edges -> Q sequence 3,2,1,0,F; BO high only while Q=0; UF becomes 1 after the 0->F edge.
REQ-024 Enable gating: Q=5 with ENP=0/ENT=1, then ENP=1/ENT=0, for 3 edges each -> Q stays 5; BO=0.
REQ-025 Priority: Q=2, LOAD_n=0, D=4'hA, ENP=ENT=1 -> Q=A after one edge and UF cleared; the decrement is ignored.
REQ-026 Cascade: two instances, low BO driving high ENT, both loaded 8'h01, counting -> 01,00,FF; high stage decrements only on the low-stage 0->F edge.
REQ-027 Auto-reload (macro defined): load D=4'h2, count 6 edges -> 2,1,0,2,1,0,2; UF=1 after the first 0->2 edge; after a reset, a count from 0 gives F.
